// File: rtl/hilo_muldiv_pkg.sv
// Shared constants, op encodings and FSM states for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   // Quotient returned for any divide by zero
   localparam logic [XLEN-1:0] DIV0_QUOT = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } md_state_t;

endpackage

// File: rtl/hilo_muldiv_unit_iter.sv
// One iteration of the shift-add multiplier or the restoring divider on {hi,lo}.
module muldiv_iter
   import hilo_muldiv_pkg::*;
(
   input  logic            is_div,
   input  logic [XLEN-1:0] acc_hi,
   input  logic [XLEN-1:0] acc_lo,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] next_hi,
   output logic [XLEN-1:0] next_lo
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rem_sh;

   // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
   // Divide: shift {rem,quo} left, keep the trial difference only when it does not borrow.
   always_comb begin
      sum     = {1'b0, acc_hi};
      rem_sh  = {acc_hi, acc_lo[XLEN-1]};
      next_hi = acc_hi;
      next_lo = acc_lo;
      if (is_div) begin
         if (rem_sh >= {1'b0, operand}) begin
            next_hi = rem_sh[XLEN-1:0] - operand;
            next_lo = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            next_hi = rem_sh[XLEN-1:0];
            next_lo = {acc_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         if (acc_lo[0]) begin
            sum = {1'b0, acc_hi} + {1'b0, operand};
         end
         next_hi = sum[XLEN:1];
         next_lo = {sum[0], acc_lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair, with mthi/mtlo writes.
module hilo_muldiv_unit
   import hilo_muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            mthi,
   input  logic            mtlo,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   md_state_t         state;
   md_state_t         state_next;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   acc_hi;
   logic [XLEN-1:0]   acc_lo;
   logic [XLEN-1:0]   operand;
   logic [XLEN-1:0]   orig_a;
   logic              is_div;
   logic              neg_res;
   logic              neg_rem;
   logic              div_zero;
   logic [XLEN-1:0]   step_hi;
   logic [XLEN-1:0]   step_lo;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic              last_iter;

   assign last_iter = (cnt == CNT_W'(XLEN - 1));

   muldiv_iter u_iter (
      .is_div  (is_div),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );

   // Signed ops work on magnitudes; the signs are recorded for the final fix-up.
   always_comb begin
      a_neg = op[0] & a[XLEN-1];
      b_neg = op[0] & b[XLEN-1];
      a_mag = a_neg ? (~a + 1'b1) : a;
      b_mag = b_neg ? (~b + 1'b1) : b;
   end

   // Sign-corrected results presented to HI/LO in the FIX cycle.
   always_comb begin
      prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quo_fix  = neg_res ? -acc_lo : acc_lo;
      rem_fix  = neg_rem ? -acc_hi : acc_hi;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; busy covers every non-idle state.
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_iter) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, iteration datapath, HI/LO writes and the done pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         operand  <= '0;
         orig_a   <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt      <= '0;
                  is_div   <= op[1];
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  orig_a   <= a;
                  div_zero <= (b == '0);
                  acc_hi   <= '0;
                  acc_lo   <= op[1] ? a_mag : b_mag;
                  operand  <= op[1] ? b_mag : a_mag;
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + 1'b1;
            end
            FIX: begin
               done <= 1'b1;
               if (is_div) begin
                  if (div_zero) begin
                     hi <= orig_a;
                     lo <= DIV0_QUOT;
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
               end else begin
                  hi <= prod_fix[2*XLEN-1:XLEN];
                  lo <= prod_fix[XLEN-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that produces the HI/LO register pair consumed by mfhi/mflo, and accepts direct HI/LO writes (mthi/mtlo).
- Sits beside the single-cycle ALU in the execute stage and replaces its combinational `lo = a*b` path.
- Performs iterative shift-add multiply and restoring divide, one bit per cycle, with a start/busy/done handshake to the pipeline control.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk)
- start  in  1  launch request, sampled only in IDLE
- op  in  2  00 multu, 01 mult, 10 divu, 11 div
- a  in  XLEN  multiplicand / dividend (rs)
- b  in  XLEN  multiplier / divisor (rt)
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  XLEN  data for mthi/mtlo
- busy  out  1  operation in progress; pipeline stalls mfhi/mflo while high
- done  out  1  one-cycle pulse, HI/LO hold the new result
- hi  out  XLEN  HI register (product high half / remainder)
- lo  out  XLEN  LO register (product low half / quotient)

Behaviour:
- Reset (rst==0 at an edge): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation and produces no done and no HI/LO update.
- States:
  - IDLE -> RUN on start.
  - RUN loops 32 iterations, then -> FIX.
  - FIX -> IDLE.
- Timing, with start sampled at edge E0:
  - busy=1 after E0 through E33.
  - RUN performs iterations at E1..E32.
  - FIX writes hi/lo at E33.
  - done=1 for exactly the cycle after E33; busy=0 in that same cycle.
  - Latency is 33 cycles from the start edge to HI/LO valid.
- Operand capture:
  - a, b and op are latched at E0; later input changes have no effect.
  - Signed ops convert both operands to magnitudes and record the result signs.
- Multiply:
  - 64-bit accumulator {hi_acc, lo_acc}. Each iteration: if the multiplier LSB is 1, add the multiplicand to the upper half with a 33-bit carry; then shift the accumulator right by 1.
  - FIX negates the 64-bit product if the signs differ.
- Divide:
  - Restoring divide. Each iteration: shift {rem, quo} left by 1; trial subtract the divisor from rem; if it does not borrow, keep the difference and set quo[0]=1.
  - FIX negates the quotient if the signs differ and negates the remainder if the dividend was negative.
- Wrap-around: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- Divide by zero: divu and div both give lo=0xFFFFFFFF, hi=a (original dividend). The full 33 cycles are still taken.
- Handshake rules:
  - start while busy is ignored.
  - mthi/mtlo while busy are ignored.
  - In IDLE, mthi/mtlo update the register at the edge; mthi and mtlo together update both.
  - start and mthi/mtlo in the same IDLE cycle: start wins and the writes are dropped.
  - hi/lo change only at FIX, on mthi/mtlo, or on reset.

Decomposition:
- Shared package holds:
  - XLEN.
  - op encodings MD_MULTU, MD_MULT, MD_DIVU, MD_DIV.
  - State enum IDLE/RUN/FIX.
  - DIV0_QUOT constant (all ones).
- One sub-module, muldiv_iter: a combinational single-iteration step (add/shift or subtract/shift) selected by the is_div flag.
- FSM, counter, sign fix-up and HI/LO registers stay in the top module.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly once, 33 cycles after start; busy high for 33 cycles.
- mult a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu a=100 b=7 -> lo=14, hi=2.
- divu a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064. div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- IDLE: mthi wdata=0x12345678, then mtlo wdata=0xCAFEBABE -> hi/lo read back. Start multu 3*5, then assert mthi and a second start mid-run -> both ignored; final hi=0, lo=15.
- Start divu; drive rst=0 at cycle 10 after start -> next cycle busy=0, hi=lo=0, no done pulse. After release, a fresh multu 2*2 gives lo=4.
